// File: rtl/elevator_step_tracker.sv
// Tracks elevator car position by decoding a 4-wire stepper phase word into
// up/down steps, counting floors, and flagging skipped, illegal and out-of-range motion.
module elevator_step_tracker #(
    parameter int STEPS_PER_FLOOR = 200,
    parameter int NUM_FLOORS      = 8,
    parameter int STALL_CYCLES    = 480000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] motor_in,
    input  logic       clr_err,
    output logic       step_pulse,
    output logic       step_dir,
    output logic [2:0] floor,
    output logic [7:0] step_in_floor,
    output logic       arrive,
    output logic       moving,
    output logic       err_skip,
    output logic       err_illegal,
    output logic       err_limit
);

    localparam int                IDLE_W    = $clog2(STALL_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(STALL_CYCLES);
    localparam logic [7:0]        SIF_MAX   = 8'(STEPS_PER_FLOOR - 1);
    localparam logic [2:0]        TOP_FLOOR = 3'(NUM_FLOORS - 1);

    typedef enum logic {UNANCHORED, ANCHORED} state_t;

    state_t            state;
    logic [3:0]        phase_q;
    logic [1:0]        last_phase;
    logic [IDLE_W-1:0] idle_cnt;

    logic              code_valid, code_zero;
    logic [1:0]        code_idx, delta;
    logic              want_up, want_down, set_skip, set_illegal, set_limit;
    logic              accept_up, accept_down, accept;
    logic [7:0]        sif_next;
    logic [2:0]        floor_next;
    logic [IDLE_W-1:0] idle_next;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        code_valid = 1'b1;
        code_zero  = 1'b0;
        code_idx   = 2'd0;
        case (phase_q)
            4'b1001: code_idx = 2'd0;
            4'b1010: code_idx = 2'd1;
            4'b0110: code_idx = 2'd2;
            4'b0101: code_idx = 2'd3;
            4'b0000: begin code_valid = 1'b0; code_zero = 1'b1; end
            default: code_valid = 1'b0;
        endcase
    end

    // Phase distance wraps naturally in 2 bits: 1 = up, 3 = down, 2 = skipped phase.
    assign delta       = code_idx - last_phase;
    assign want_up     = (state == ANCHORED) && code_valid && (delta == 2'd1);
    assign want_down   = (state == ANCHORED) && code_valid && (delta == 2'd3);
    assign set_skip    = (state == ANCHORED) && code_valid && (delta == 2'd2);
    assign set_illegal = !code_valid && !code_zero;

    assign accept_up   = want_up   && !(floor == TOP_FLOOR && step_in_floor == 8'd0);
    assign accept_down = want_down && !(floor == 3'd0      && step_in_floor == 8'd0);
    assign accept      = accept_up || accept_down;
    assign set_limit   = (want_up && !accept_up) || (want_down && !accept_down);

    always_comb begin
        sif_next   = step_in_floor;
        floor_next = floor;
        if (accept_up) begin
            if (step_in_floor == SIF_MAX) begin
                sif_next   = 8'd0;
                floor_next = floor + 3'd1;
            end else begin
                sif_next   = step_in_floor + 8'd1;
            end
        end else if (accept_down) begin
            if (step_in_floor == 8'd0) begin
                sif_next   = SIF_MAX;
                floor_next = floor - 3'd1;
            end else begin
                sif_next   = step_in_floor - 8'd1;
            end
        end
    end

    assign idle_next = accept ? '0 :
                       (idle_cnt == IDLE_MAX) ? IDLE_MAX : idle_cnt + IDLE_W'(1);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q       <= 4'b0000;
            state         <= UNANCHORED;
            last_phase    <= 2'd0;
            floor         <= 3'd0;
            step_in_floor <= 8'd0;
            step_dir      <= 1'b0;
            step_pulse    <= 1'b0;
            arrive        <= 1'b0;
            moving        <= 1'b0;
            idle_cnt      <= IDLE_MAX;
            err_skip      <= 1'b0;
            err_illegal   <= 1'b0;
            err_limit     <= 1'b0;
        end else begin
            phase_q    <= motor_in;
            step_pulse <= 1'b0;
            arrive     <= 1'b0;
            idle_cnt   <= idle_next;
            if (accept)
                moving <= 1'b1;
            else if (idle_next == IDLE_MAX)
                moving <= 1'b0;

            case (state)
                UNANCHORED: begin
                    if (code_valid) begin
                        last_phase <= code_idx;
                        state      <= ANCHORED;
                    end
                end
                ANCHORED: begin
                    if (code_zero) begin
                        state <= UNANCHORED;
                    end else if (code_valid) begin
                        // Rejected limit steps and skips still re-anchor on the new phase.
                        last_phase <= code_idx;
                        if (accept) begin
                            step_pulse    <= 1'b1;
                            step_dir      <= accept_down;
                            floor         <= floor_next;
                            step_in_floor <= sif_next;
                            arrive        <= (sif_next == 8'd0);
                        end
                    end
                end
                default: state <= UNANCHORED;
            endcase

            // A new error in the same cycle wins over clr_err.
            err_skip    <= set_skip    || (err_skip    && !clr_err);
            err_illegal <= set_illegal || (err_illegal && !clr_err);
            err_limit   <= set_limit   || (err_limit   && !clr_err);
        end
    end

endmodule

// File: tb/tb_elevator_step_tracker.sv
// Scoreboard bench for elevator_step_tracker: a position model pushes expected
// step events, a negedge monitor pops and compares them as step_pulse appears.
module tb_elevator_step_tracker;

    localparam int SPF   = 200;
    localparam int NF    = 8;
    localparam int STALL = 1000;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] motor_in;
    logic       clr_err;
    logic       step_pulse, step_dir, arrive, moving;
    logic [2:0] floor;
    logic [7:0] step_in_floor;
    logic       err_skip, err_illegal, err_limit;

    elevator_step_tracker #(
        .STEPS_PER_FLOOR(SPF),
        .NUM_FLOORS     (NF),
        .STALL_CYCLES   (STALL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .motor_in     (motor_in),
        .clr_err      (clr_err),
        .step_pulse   (step_pulse),
        .step_dir     (step_dir),
        .floor        (floor),
        .step_in_floor(step_in_floor),
        .arrive       (arrive),
        .moving       (moving),
        .err_skip     (err_skip),
        .err_illegal  (err_illegal),
        .err_limit    (err_limit)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       dir;
        logic [2:0] fl;
        logic [7:0] sif;
        logic       arr;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         pulse_cnt = 0;
    logic [3:0] phase_tab [4] = '{4'b1001, 4'b1010, 4'b0110, 4'b0101};
    int         cur = 0;
    int         m_fl = 0;
    int         m_sif = 0;

    // Monitor: every accepted step must match the next scoreboard entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (arrive && !step_pulse) begin
                checks++; errors++;
                $display("FAIL arrive_without_step: arrive=%b step_pulse=%b", arrive, step_pulse);
            end
            if (step_pulse) begin
                exp_t e;
                pulse_cnt++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_step: dir=%b floor=%0d sif=%0d", step_dir, floor, step_in_floor);
                end else begin
                    e = sb.pop_front();
                    if ({step_dir, floor, step_in_floor, arrive} !== e) begin
                        errors++;
                        $display("FAIL step_event: got dir=%b floor=%0d sif=%0d arrive=%b, want dir=%b floor=%0d sif=%0d arrive=%b",
                                 step_dir, floor, step_in_floor, arrive, e.dir, e.fl, e.sif, e.arr);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        sb.delete();
        m_fl  = 0;
        m_sif = 0;
    endtask

    // Advance the model by one accepted step, push the expectation, then drive the phase.
    task automatic do_step(input logic down, input int gap);
        exp_t e;
        if (!down) begin
            cur = (cur + 1) % 4;
            if (m_sif == SPF - 1) begin m_sif = 0; m_fl++; end
            else m_sif++;
        end else begin
            cur = (cur + 3) % 4;
            if (m_sif == 0) begin m_sif = SPF - 1; m_fl--; end
            else m_sif--;
        end
        e.dir = down; e.fl = 3'(m_fl); e.sif = 8'(m_sif); e.arr = (m_sif == 0);
        sb.push_back(e);
        motor_in = phase_tab[cur];
        repeat (gap) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; clr_err = 1'b0; motor_in = 4'b0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({step_pulse, step_dir, floor, step_in_floor, arrive, moving, err_skip, err_illegal, err_limit} !== 17'd0) begin
            errors++;
            $display("FAIL reset_values: got pulse=%b dir=%b floor=%0d sif=%0d arrive=%b moving=%b errs=%b%b%b, want all 0",
                     step_pulse, step_dir, floor, step_in_floor, arrive, moving, err_skip, err_illegal, err_limit);
        end
    endtask

    task automatic test_up_steps();
        int p0 = pulse_cnt;
        cur = 0;
        motor_in = phase_tab[0];
        repeat (10) @(negedge clk);
        checks++;
        if (pulse_cnt !== p0) begin
            errors++; $display("FAIL anchor_no_step: pulses=%0d want 0", pulse_cnt - p0);
        end
        for (int i = 0; i < 4; i++) do_step(1'b0, 10);
        checks++;
        if (pulse_cnt - p0 !== 4) begin
            errors++; $display("FAIL up_pulse_count: got %0d want 4", pulse_cnt - p0);
        end
        checks++;
        if ({floor, step_in_floor, step_dir, moving} !== {3'd0, 8'd4, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL up_position: got floor=%0d sif=%0d dir=%b moving=%b want 0 4 0 1", floor, step_in_floor, step_dir, moving);
        end
    endtask

    task automatic test_floor_wrap();
        for (int n = 0; n < 2000 && !(m_fl == 2 && m_sif == SPF - 1); n++) do_step(1'b0, 2);
        repeat (4) @(negedge clk);
        checks++;
        if ({floor, step_in_floor} !== {3'd2, 8'(SPF - 1)}) begin
            errors++; $display("FAIL pre_wrap_pos: got floor=%0d sif=%0d want 2 %0d", floor, step_in_floor, SPF - 1);
        end
        do_step(1'b0, 10);
        checks++;
        if ({floor, step_in_floor} !== {3'd3, 8'd0}) begin
            errors++; $display("FAIL up_wrap_pos: got floor=%0d sif=%0d want 3 0", floor, step_in_floor);
        end
        do_step(1'b1, 10);
        checks++;
        if ({floor, step_in_floor, step_dir} !== {3'd2, 8'(SPF - 1), 1'b1}) begin
            errors++; $display("FAIL down_wrap_pos: got floor=%0d sif=%0d dir=%b want 2 %0d 1", floor, step_in_floor, step_dir, SPF - 1);
        end
        do_step(1'b0, 10);
    endtask

    task automatic test_limit_top();
        int p0;
        for (int n = 0; n < 2000 && !(m_fl == NF - 1 && m_sif == 0); n++) do_step(1'b0, 2);
        repeat (4) @(negedge clk);
        p0 = pulse_cnt;
        cur = (cur + 1) % 4;
        motor_in = phase_tab[cur];
        repeat (10) @(negedge clk);
        checks++;
        if ({err_limit, floor, step_in_floor} !== {1'b1, 3'(NF - 1), 8'd0} || pulse_cnt !== p0) begin
            errors++;
            $display("FAIL top_limit: got err_limit=%b floor=%0d sif=%0d pulses=%0d want 1 %0d 0 0",
                     err_limit, floor, step_in_floor, pulse_cnt - p0, NF - 1);
        end
        do_step(1'b1, 10);
        checks++;
        if ({floor, step_in_floor} !== {3'(NF - 2), 8'(SPF - 1)}) begin
            errors++; $display("FAIL top_limit_relatch: got floor=%0d sif=%0d want %0d %0d", floor, step_in_floor, NF - 2, SPF - 1);
        end
    endtask

    task automatic test_limit_bottom();
        int p0;
        apply_reset();
        cur = 0;
        motor_in = phase_tab[0];
        repeat (10) @(negedge clk);
        p0 = pulse_cnt;
        cur = 3;
        motor_in = phase_tab[3];
        repeat (10) @(negedge clk);
        checks++;
        if ({err_limit, err_skip, err_illegal, floor, step_in_floor} !== {3'b100, 3'd0, 8'd0} || pulse_cnt !== p0) begin
            errors++;
            $display("FAIL bottom_limit: got lim/skip/ill=%b%b%b floor=%0d sif=%0d pulses=%0d want 100 0 0 0",
                     err_limit, err_skip, err_illegal, floor, step_in_floor, pulse_cnt - p0);
        end
        do_step(1'b0, 10);
        checks++;
        if ({floor, step_in_floor} !== {3'd0, 8'd1}) begin
            errors++; $display("FAIL bottom_relatch: got floor=%0d sif=%0d want 0 1", floor, step_in_floor);
        end
    endtask

    task automatic test_errors();
        int p0;
        apply_reset();
        cur = 0;
        motor_in = phase_tab[0];
        repeat (10) @(negedge clk);
        p0 = pulse_cnt;
        cur = 2;
        motor_in = phase_tab[2];
        repeat (10) @(negedge clk);
        checks++;
        if ({err_skip, err_illegal, err_limit, floor, step_in_floor} !== {3'b100, 3'd0, 8'd0} || pulse_cnt !== p0) begin
            errors++;
            $display("FAIL skip: got skip/ill/lim=%b%b%b floor=%0d sif=%0d pulses=%0d want 100 0 0 0",
                     err_skip, err_illegal, err_limit, floor, step_in_floor, pulse_cnt - p0);
        end
        motor_in = 4'b1111;
        repeat (10) @(negedge clk);
        checks++;
        if ({err_skip, err_illegal, err_limit} !== 3'b110) begin
            errors++; $display("FAIL illegal: got skip/ill/lim=%b%b%b want 110", err_skip, err_illegal, err_limit);
        end
        motor_in = phase_tab[cur];
        repeat (4) @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
        checks++;
        if ({err_skip, err_illegal, err_limit} !== 3'b000 || pulse_cnt !== p0) begin
            errors++;
            $display("FAIL clr_err: got skip/ill/lim=%b%b%b pulses=%0d want 000 0", err_skip, err_illegal, err_limit, pulse_cnt - p0);
        end
    endtask

    task automatic test_stall();
        int  n = 0;
        bit  seen = 0;
        do_step(1'b0, 0);
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = step_pulse;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL stall_step_seen: got no step_pulse within 10 cycles, want 1");
        end
        while (moving && n < STALL + 20) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== STALL) begin
            errors++; $display("FAIL stall_moving_cycles: got %0d want %0d", n, STALL);
        end
        cur = (cur + 2) % 4;
        motor_in = phase_tab[cur];
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        checks++;
        if (err_skip !== 1'b1) begin
            errors++; $display("FAIL skip_beats_clr: got err_skip=%b want 1", err_skip);
        end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
        checks++;
        if (err_skip !== 1'b0) begin
            errors++; $display("FAIL skip_cleared: got err_skip=%b want 0", err_skip);
        end
    endtask

    task automatic test_reset_mid();
        int p0;
        for (int i = 0; i < 5; i++) do_step(1'b0, 2);
        do_step(1'b0, 10);
        cur = (cur + 1) % 4;
        motor_in = phase_tab[cur];
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({step_pulse, step_dir, floor, step_in_floor, arrive, moving, err_skip, err_illegal, err_limit} !== 17'd0) begin
            errors++;
            $display("FAIL async_reset: got pulse=%b dir=%b floor=%0d sif=%0d arrive=%b moving=%b errs=%b%b%b want all 0",
                     step_pulse, step_dir, floor, step_in_floor, arrive, moving, err_skip, err_illegal, err_limit);
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        p0 = pulse_cnt;
        repeat (10) @(negedge clk);
        checks++;
        if (pulse_cnt !== p0) begin
            errors++; $display("FAIL post_reset_anchor: got %0d pulses want 0", pulse_cnt - p0);
        end
        do_step(1'b0, 10);
        checks++;
        if ({floor, step_in_floor} !== {3'd0, 8'd1}) begin
            errors++; $display("FAIL post_reset_pos: got floor=%0d sif=%0d want 0 1", floor, step_in_floor);
        end
    endtask

    initial begin
        rst = 1'b1; clr_err = 1'b0; motor_in = 4'b0000;
        test_reset();
        test_up_steps();
        test_floor_wrap();
        test_limit_top();
        test_limit_bottom();
        test_errors();
        test_stall();
        test_reset_mid();
        repeat (5) @(negedge clk);
        checks++;
        if (sb.size() !== 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d pending steps want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
